// File: rtl/fp32_mul_pipe.sv
// Two-stage pipelined IEEE-754 single-precision multiplier (flush-to-zero, round-to-nearest-even).
// Stage 1 splits fields, classifies operands and forms the 48-bit product; stage 2 normalizes, rounds and packs.
module fp32_mul_pipe #(
   parameter int unsigned EXP_BIAS = 127,
   parameter logic [31:0] QNAN     = 32'h7FC00000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic [31:0] result,
   output logic        flag_invalid,
   output logic        flag_overflow,
   output logic        flag_underflow,
   output logic        flag_inexact
);

   typedef enum logic [1:0] {CLS_ZERO, CLS_NORMAL, CLS_INF, CLS_NAN} op_class_e;

   // Exponent 0 is always zero here: subnormal inputs are flushed regardless of fraction.
   function automatic op_class_e classify(input logic [30:0] x);
      if (x[30:23] == 8'h00)
         return CLS_ZERO;
      else if (x[30:23] != 8'hFF)
         return CLS_NORMAL;
      else if (x[22:0] == 23'd0)
         return CLS_INF;
      else
         return CLS_NAN;
   endfunction

   op_class_e         cls_a, cls_b;
   logic              sign_c, snan_a, snan_b;
   logic              special_c, special_inv_c;
   logic [31:0]       special_res_c;
   logic [23:0]       mant_a, mant_b;
   logic [47:0]       prod_c;
   logic signed [9:0] exp_c;

   logic              s1_valid, s1_sign, s1_special, s1_special_inv;
   logic [31:0]       s1_special_res;
   logic [47:0]       s1_prod;
   logic signed [9:0] s1_exp;

   always_comb begin
      cls_a         = classify(a[30:0]);
      cls_b         = classify(b[30:0]);
      sign_c        = a[31] ^ b[31];
      snan_a        = (cls_a == CLS_NAN) && !a[22];
      snan_b        = (cls_b == CLS_NAN) && !b[22];
      mant_a        = (cls_a == CLS_ZERO) ? 24'd0 : {1'b1, a[22:0]};
      mant_b        = (cls_b == CLS_ZERO) ? 24'd0 : {1'b1, b[22:0]};
      prod_c        = {24'd0, mant_a} * {24'd0, mant_b};
      exp_c         = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]})
                      - $signed(10'(EXP_BIAS));
      special_c     = 1'b1;
      special_inv_c = 1'b0;
      special_res_c = {sign_c, 31'd0};
      // Special operands resolved in priority order: NaN, Inf*0, Inf, zero.
      if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
         special_res_c = QNAN;
         special_inv_c = snan_a | snan_b;
      end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                   (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
         special_res_c = QNAN;
         special_inv_c = 1'b1;
      end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
         special_res_c = {sign_c, 8'hFF, 23'd0};
      end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
         special_res_c = {sign_c, 31'd0};
      end else begin
         special_c = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid       <= 1'b0;
         s1_sign        <= 1'b0;
         s1_special     <= 1'b0;
         s1_special_inv <= 1'b0;
         s1_special_res <= 32'd0;
         s1_prod        <= 48'd0;
         s1_exp         <= 10'sd0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign        <= sign_c;
            s1_special     <= special_c;
            s1_special_inv <= special_inv_c;
            s1_special_res <= special_res_c;
            s1_prod        <= prod_c;
            s1_exp         <= exp_c;
         end
      end
   end

   logic [22:0]       mant_n, frac_r;
   logic              guard, sticky, round_up, carry;
   logic signed [9:0] exp_n;
   logic [31:0]       res_c;
   logic              inv_c, ovf_c, unf_c, inx_c;

   always_comb begin
      if (s1_prod[47]) begin
         mant_n = s1_prod[46:24];
         guard  = s1_prod[23];
         sticky = |s1_prod[22:0];
      end else begin
         mant_n = s1_prod[45:23];
         guard  = s1_prod[22];
         sticky = |s1_prod[21:0];
      end
      round_up        = guard & (sticky | mant_n[0]);
      // A carry out of the all-ones fraction leaves frac_r at zero and bumps the exponent.
      {carry, frac_r} = {1'b0, mant_n} + {23'd0, round_up};
      exp_n           = s1_exp + $signed({9'd0, s1_prod[47]}) + $signed({9'd0, carry});
      res_c           = {s1_sign, exp_n[7:0], frac_r};
      inv_c           = 1'b0;
      ovf_c           = 1'b0;
      unf_c           = 1'b0;
      inx_c           = guard | sticky;
      if (s1_special) begin
         res_c = s1_special_res;
         inv_c = s1_special_inv;
         inx_c = 1'b0;
      end else if (exp_n >= 10'sd255) begin
         res_c = {s1_sign, 8'hFF, 23'd0};
         ovf_c = 1'b1;
         inx_c = 1'b1;
      end else if (exp_n <= 10'sd0) begin
         res_c = {s1_sign, 31'd0};
         unf_c = 1'b1;
         inx_c = 1'b1;
      end
   end

   // Result holds between operations; flags are only meaningful alongside out_valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid      <= 1'b0;
         result         <= 32'd0;
         flag_invalid   <= 1'b0;
         flag_overflow  <= 1'b0;
         flag_underflow <= 1'b0;
         flag_inexact   <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result         <= res_c;
            flag_invalid   <= inv_c;
            flag_overflow  <= ovf_c;
            flag_underflow <= unf_c;
            flag_inexact   <= inx_c;
         end else begin
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Scoreboard bench for fp32_mul_pipe: directed vectors, back-to-back burst, random soak and mid-stream reset.
// Flag vectors are ordered {invalid, overflow, underflow, inexact}.
module tb_fp32_mul_pipe;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [31:0] a, b;
   logic        out_valid;
   logic [31:0] result;
   logic        flag_invalid, flag_overflow, flag_underflow, flag_inexact;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      int          cyc;
   } sb_t;

   sb_t sb_q[$];
   int  errors = 0;
   int  checks = 0;
   int  cycle_cnt = 0;
   int  run_len = 0;
   int  last_run = 0;

   fp32_mul_pipe dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .a              (a),
      .b              (b),
      .out_valid      (out_valid),
      .result         (result),
      .flag_invalid   (flag_invalid),
      .flag_overflow  (flag_overflow),
      .flag_underflow (flag_underflow),
      .flag_inexact   (flag_inexact)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: observed=%h required=%h", tag, got, exp);
      end
   endtask

   // Independent reference: exact integer product, remainder-based rounding.
   function automatic void refModel(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic [3:0] f);
      int              ex, ey, e, shift;
      longint unsigned mx, my, p, q, rem, half;
      logic            s, nan_x, nan_y, inf_x, inf_y, zero_x, zero_y;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      s = x[31] ^ y[31];
      nan_x = (ex == 255) && (x[22:0] != 0);
      nan_y = (ey == 255) && (y[22:0] != 0);
      inf_x = (ex == 255) && (x[22:0] == 0);
      inf_y = (ey == 255) && (y[22:0] == 0);
      zero_x = (ex == 0);
      zero_y = (ey == 0);
      f = 4'b0000;
      if (nan_x || nan_y) begin
         r = 32'h7FC00000;
         f[3] = (nan_x && !x[22]) || (nan_y && !y[22]);
      end else if ((inf_x && zero_y) || (zero_x && inf_y)) begin
         r = 32'h7FC00000;
         f[3] = 1'b1;
      end else if (inf_x || inf_y) begin
         r = {s, 8'hFF, 23'd0};
      end else if (zero_x || zero_y) begin
         r = {s, 31'd0};
      end else begin
         mx = 64'h800000 | 64'(x[22:0]);
         my = 64'h800000 | 64'(y[22:0]);
         p = mx * my;
         e = ex + ey - 127;
         shift = 23;
         if (p >= 64'h8000_0000_0000) begin
            shift = 24;
            e++;
         end
         q = p >> shift;
         rem = p & ((64'd1 << shift) - 1);
         half = 64'd1 << (shift - 1);
         if (rem > half || (rem == half && q[0])) q++;
         if (q == 64'h100_0000) begin
            q = q >> 1;
            e++;
         end
         if (e >= 255) begin
            r = {s, 8'hFF, 23'd0};
            f = 4'b0101;
         end else if (e <= 0) begin
            r = {s, 31'd0};
            f = 4'b0011;
         end else begin
            r = {s, e[7:0], q[22:0]};
            f = {3'b000, rem != 0};
         end
      end
   endfunction

   function automatic logic [31:0] randOperand();
      logic [31:0] x;
      logic [31:0] specials [7];
      specials = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000,
                   32'h7FC00000, 32'h7F800001, 32'h3F800000};
      x = $urandom;
      case ($urandom_range(0, 3))
         0: ;
         1: x[30:23] = 8'($urandom_range(100, 154));
         2: x[30:23] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 50))
                                                   : 8'($urandom_range(200, 254));
         default: x = specials[$urandom_range(0, 6)];
      endcase
      return x;
   endfunction

   // Drives one operation for one cycle and leaves in_valid high for back-to-back use.
   task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] er, input logic [3:0] ef);
      sb_t e;
      a = av;
      b = bv;
      in_valid = 1'b1;
      e.res = er;
      e.flg = ef;
      e.cyc = cycle_cnt;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic applyModelled(input logic [31:0] av, input logic [31:0] bv);
      logic [31:0] r;
      logic [3:0]  f;
      refModel(av, bv, r, f);
      applyStimulus(av, bv, r, f);
   endtask

   task automatic idleCycles(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drainScoreboard();
      int n = 0;
      in_valid = 1'b0;
      while (sb_q.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("drain", 32'(sb_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      sb_t e;
      if (out_valid) begin
         run_len++;
         checkOutput("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checkOutput("result", result, e.res);
            checkOutput("flags", {28'd0, flag_invalid, flag_overflow, flag_underflow, flag_inexact},
                        {28'd0, e.flg});
            checkOutput("latency", 32'(cycle_cnt - e.cyc), 32'd2);
         end
      end else begin
         if (run_len != 0) last_run = run_len;
         run_len = 0;
         checkOutput("idle_flags", {28'd0, flag_invalid, flag_overflow, flag_underflow, flag_inexact},
                     32'd0);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] dir_a [13];
      logic [31:0] dir_b [13];
      logic [31:0] dir_r [13];
      logic [3:0]  dir_f [13];
      dir_a = '{32'h3FC00000, 32'hC0000000, 32'h3F800000, 32'h3F800001, 32'h7F000000,
                32'h00800000, 32'h00000001, 32'h7F800000, 32'h7FC00001, 32'h7F800001,
                32'hFF800000, 32'h80000000, 32'h3F800001};
      dir_b = '{32'h40000000, 32'h40400000, 32'h3F70F0F1, 32'h3F800001, 32'h7F000000,
                32'h3F000000, 32'h40000000, 32'h00000000, 32'h3F800000, 32'h3F800000,
                32'h40000000, 32'h40400000, 32'h3FC00000};
      dir_r = '{32'h40400000, 32'hC0C00000, 32'h3F70F0F1, 32'h3F800002, 32'h7F800000,
                32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                32'hFF800000, 32'h80000000, 32'h3FC00002};
      dir_f = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0101,
                4'b0011, 4'b0000, 4'b1000, 4'b0000, 4'b1000,
                4'b0000, 4'b0000, 4'b0001};

      reset_n = 1'b0;
      in_valid = 1'b0;
      a = 32'd0;
      b = 32'd0;
      #2;
      checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_result", result, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      idleCycles(2);

      $display("[TB] directed vectors");
      for (int i = 0; i < 13; i++) begin
         applyStimulus(dir_a[i], dir_b[i], dir_r[i], dir_f[i]);
         idleCycles(3);
      end

      $display("[TB] back-to-back burst");
      for (int i = 0; i < 8; i++) begin
         logic [31:0] x, y;
         x = $urandom;
         y = $urandom;
         x[30:23] = 8'($urandom_range(100, 154));
         y[30:23] = 8'($urandom_range(100, 154));
         applyModelled(x, y);
      end
      idleCycles(5);
      checkOutput("burst_run", 32'(last_run), 32'd8);

      $display("[TB] random soak");
      for (int i = 0; i < 150; i++) begin
         applyModelled(randOperand(), randOperand());
         if ($urandom_range(0, 2) == 0) idleCycles(1);
      end
      drainScoreboard();

      $display("[TB] mid-stream reset");
      for (int i = 0; i < 4; i++) applyModelled(32'h40000000 + 32'(i), 32'h3FC00000);
      #2;
      reset_n = 1'b0;
      in_valid = 1'b0;
      #1;
      checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_result", result, 32'd0);
      checkOutput("rst_flags", {28'd0, flag_invalid, flag_overflow, flag_underflow, flag_inexact},
                  32'd0);
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_hold_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_hold_result", result, 32'd0);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_rst_idle", {31'd0, out_valid}, 32'd0);
      applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
      drainScoreboard();
      idleCycles(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
